// File: rtl/alu_pkg.sv
// Op-code constants and FSM state type shared by the execute-stage ALU and ALU control.
package alu_pkg;

   localparam logic [2:0] ALU_AND  = 3'd0;
   localparam logic [2:0] ALU_XOR  = 3'd1;
   localparam logic [2:0] ALU_SLL  = 3'd2;
   localparam logic [2:0] ALU_ADD  = 3'd3;
   localparam logic [2:0] ALU_SUB  = 3'd4;
   localparam logic [2:0] ALU_MUL  = 3'd5;
   localparam logic [2:0] ALU_SRAI = 3'd6;

   typedef enum logic {
      IDLE = 1'b0,
      MUL  = 1'b1
   } alu_state_e;

endpackage

// File: rtl/mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles after start.
module mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   logic [WIDTH-1:0] mcd_q;
   logic [WIDTH-1:0] mpr_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_next;
   logic [CW-1:0]    cnt_q;
   logic             run_q;

   assign acc_next = acc_q + (mpr_q[0] ? mcd_q : '0);
   // done flags the final iteration so the product includes its partial sum.
   assign done     = run_q && (cnt_q == CW'(WIDTH - 1));
   assign product  = acc_next;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mcd_q <= '0;
         mpr_q <= '0;
         acc_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else if (start) begin
         mcd_q <= a;
         mpr_q <= b;
         acc_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b1;
      end else if (run_q) begin
         acc_q <= acc_next;
         mcd_q <= mcd_q << 1;
         mpr_q <= mpr_q >> 1;
         cnt_q <= cnt_q + 1'b1;
         if (done)
            run_q <= 1'b0;
      end
   end

endmodule

// File: rtl/iter_alu.sv
// Execute-stage ALU: single-cycle logic/shift/add ops, multi-cycle multiply with stall.
//
// state | meaning
// IDLE  | ready for a request; single-cycle ops complete here
// MUL   | multiply in flight, busy_o stalls the pipeline
module iter_alu
   import alu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [2:0]       aluop3_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o,
   output logic             valid_o,
   output logic             busy_o
);

   localparam int SW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   alu_state_e       state_q, state_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] alu_res;
   logic             mul_start;
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;

   mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start   (mul_start),
      .a       (a_i),
      .b       (b_i),
      .done    (mul_done),
      .product (mul_product)
   );

   // Reserved op code yields zero so the flag reads as a clean result.
   always_comb begin
      alu_res = '0;
      case (aluop3_i)
         ALU_AND:  alu_res = a_i & b_i;
         ALU_XOR:  alu_res = a_i ^ b_i;
         ALU_SLL:  alu_res = a_i << b_i[SW-1:0];
         ALU_ADD:  alu_res = a_i + b_i;
         ALU_SUB:  alu_res = a_i - b_i;
         ALU_SRAI: alu_res = $signed(a_i) >>> b_i[SW-1:0];
         default:  alu_res = '0;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      result_d  = result_q;
      zero_d    = zero_q;
      valid_d   = 1'b0;
      mul_start = 1'b0;
      case (state_q)
         IDLE: begin
            if (valid_i) begin
               if (aluop3_i == ALU_MUL) begin
                  mul_start = 1'b1;
                  state_d   = MUL;
               end else begin
                  result_d = alu_res;
                  zero_d   = (alu_res == '0);
                  valid_d  = 1'b1;
               end
            end
         end
         MUL: begin
            if (mul_done) begin
               result_d = mul_product;
               zero_d   = (mul_product == '0);
               valid_d  = 1'b1;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q  <= IDLE;
         result_q <= '0;
         zero_q   <= 1'b1;
         valid_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         result_q <= result_d;
         zero_q   <= zero_d;
         valid_q  <= valid_d;
      end
   end

   assign ready_o  = (state_q == IDLE);
   assign busy_o   = (state_q == MUL);
   assign result_o = result_q;
   assign zero_o   = zero_q;
   assign valid_o  = valid_q;

endmodule

// File: tb/tb_iter_alu.sv
// Self-checking bench for iter_alu: directed cases plus random ops against an arithmetic model.
module tb_iter_alu;

   localparam int WIDTH = 32;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             valid_i;
   logic             ready_o;
   logic [2:0]       aluop3_i;
   logic [WIDTH-1:0] a_i;
   logic [WIDTH-1:0] b_i;
   logic [WIDTH-1:0] result_o;
   logic             zero_o;
   logic             valid_o;
   logic             busy_o;

   int n_vec = 0;
   int n_err = 0;

   iter_alu #(.WIDTH(WIDTH)) dut (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .valid_i  (valid_i),
      .ready_o  (ready_o),
      .aluop3_i (aluop3_i),
      .a_i      (a_i),
      .b_i      (b_i),
      .result_o (result_o),
      .zero_o   (zero_o),
      .valid_o  (valid_o),
      .busy_o   (busy_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      logic [4:0]  sh;
      logic [63:0] prod;
      sh = b[4:0];
      case (op)
         3'd0: return a & b;
         3'd1: return a ^ b;
         3'd2: return a << sh;
         3'd3: return a + b;
         3'd4: return a - b;
         3'd5: begin
            prod = {32'd0, a} * {32'd0, b};
            return prod[31:0];
         end
         3'd6: return $signed(a) >>> sh;
         default: return 32'd0;
      endcase
   endfunction

   // One complete transaction; call at a negedge with valid_i low.
   task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      logic [31:0] exp;
      int          e;
      int          bsy;
      exp = ref_alu(op, a, b);
      e = 0;
      while (!ready_o && e < 100) begin
         @(negedge clk_i);
         e++;
      end
      chk({tag, "_ready"}, 32'(ready_o), 32'd1);
      valid_i  = 1'b1;
      aluop3_i = op;
      a_i      = a;
      b_i      = b;
      @(negedge clk_i);
      valid_i  = 1'b0;
      aluop3_i = $urandom_range(0, 7);
      e   = 0;
      bsy = 0;
      while (!valid_o && e < 200) begin
         if (busy_o) bsy++;
         @(negedge clk_i);
         e++;
      end
      chk({tag, "_lat"}, 32'(e), (op == 3'd5) ? 32'(WIDTH) : 32'd0);
      chk({tag, "_res"}, result_o, exp);
      chk({tag, "_zero"}, 32'(zero_o), 32'(exp == 32'd0));
      if (op == 3'd5) chk({tag, "_busycyc"}, 32'(bsy), 32'(WIDTH));
      chk({tag, "_rdy_at_valid"}, 32'(ready_o), 32'd1);
      @(negedge clk_i);
      chk({tag, "_pulse"}, 32'(valid_o), 32'd0);
      chk({tag, "_hold"}, result_o, exp);
   endtask

   logic [31:0] bb_exp[6];
   logic [2:0]  bb_op[6];

   initial begin
      int nv;
      logic [2:0]  rop;
      logic [31:0] ra, rb;

      rst_i    = 1'b0;
      valid_i  = 1'b0;
      aluop3_i = 3'd0;
      a_i      = '0;
      b_i      = '0;
      repeat (3) @(negedge clk_i);
      chk("rst_ready", 32'(ready_o), 32'd1);
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_result", result_o, 32'd0);
      chk("rst_zero", 32'(zero_o), 32'd1);
      chk("rst_valid", 32'(valid_o), 32'd0);
      rst_i = 1'b1;
      @(negedge clk_i);

      // back-to-back single-cycle ops
      bb_op  = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd6};
      bb_exp = '{32'h0000_0004, 32'hF0F0_1230, 32'h0F01_2340,
                 32'hF0F0_1238, 32'hF0F0_1230, 32'hFF0F_0123};
      a_i = 32'hF0F0_1234;
      b_i = 32'h0000_0004;
      for (int i = 0; i < 6; i++) begin
         valid_i  = 1'b1;
         aluop3_i = bb_op[i];
         @(negedge clk_i);
         chk($sformatf("b2b%0d_valid", i), 32'(valid_o), 32'd1);
         chk($sformatf("b2b%0d_res", i), result_o, bb_exp[i]);
         chk($sformatf("b2b%0d_ready", i), 32'(ready_o), 32'd1);
      end
      valid_i = 1'b0;
      @(negedge clk_i);
      chk("b2b_end_valid", 32'(valid_o), 32'd0);

      do_op("sub_zero", 3'd4, 32'd5, 32'd5);
      do_op("add_wrap", 3'd3, 32'hFFFF_FFFF, 32'd1);
      do_op("op7", 3'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      do_op("mul_neg", 3'd5, 32'hFFFF_FFFD, 32'd7);
      chk("mul_neg_model", ref_alu(3'd5, 32'hFFFF_FFFD, 32'd7), 32'hFFFF_FFEB);

      // MUL with an ADD request held throughout
      valid_i  = 1'b1;
      aluop3_i = 3'd5;
      a_i      = 32'h0001_0000;
      b_i      = 32'h0001_0000;
      @(negedge clk_i);
      aluop3_i = 3'd3;
      a_i      = 32'd3;
      b_i      = 32'd4;
      nv = 0;
      while (!valid_o && nv < 200) begin
         @(negedge clk_i);
         nv++;
      end
      chk("mulhold_lat", 32'(nv), 32'(WIDTH));
      chk("mulhold_res", result_o, 32'd0);
      chk("mulhold_zero", 32'(zero_o), 32'd1);
      @(negedge clk_i);
      valid_i = 1'b0;
      chk("mulhold_add_valid", 32'(valid_o), 32'd1);
      chk("mulhold_add_res", result_o, 32'd7);
      chk("mulhold_add_zero", 32'(zero_o), 32'd0);
      @(negedge clk_i);
      chk("mulhold_add_once", 32'(valid_o), 32'd0);

      // reset in the middle of a multiply
      do_op("pre_rst", 3'd3, 32'd10, 32'd20);
      valid_i  = 1'b1;
      aluop3_i = 3'd5;
      a_i      = 32'd1234;
      b_i      = 32'd5678;
      @(negedge clk_i);
      valid_i = 1'b0;
      repeat (9) @(negedge clk_i);
      chk("midrst_busy_before", 32'(busy_o), 32'd1);
      rst_i = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy_o), 32'd0);
      chk("midrst_ready", 32'(ready_o), 32'd1);
      chk("midrst_result", result_o, 32'd0);
      chk("midrst_zero", 32'(zero_o), 32'd1);
      @(negedge clk_i);
      rst_i = 1'b1;
      nv = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk_i);
         if (valid_o) nv++;
      end
      chk("midrst_no_valid", 32'(nv), 32'd0);

      // randomized ops
      for (int i = 0; i < 40; i++) begin
         rop = 3'($urandom_range(0, 7));
         ra  = $urandom;
         rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
         do_op($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/iter_alu.md
# iter_alu

Execute-stage ALU that consumes the 3-bit operation code produced by ALU control and computes the result for the lab CPU datapath. AND/XOR/SLL/ADD/SUB/SRAI complete in one cycle. MUL is a 32-iteration shift-add sequence. A valid/ready handshake lets the hazard unit stall the pipeline while a multiply is in flight.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width; MUL iteration count equals `WIDTH`.

Ports:
- `clk_i`, in, 1: single clock; all state updates on the rising edge.
- `rst_i`, in, 1: reset, asynchronous, active-low.
- `valid_i`, in, 1: operation request; accepted on a cycle where `valid_i && ready_o`.
- `ready_o`, out, 1: high when the block can accept a request (IDLE).
- `aluop3_i`, in, 3: 0 AND, 1 XOR, 2 SLL, 3 ADD, 4 SUB, 5 MUL, 6 SRAI, 7 reserved.
- `a_i`, in, WIDTH: operand rs1.
- `b_i`, in, WIDTH: operand rs2 or sign-extended immediate.
- `result_o`, out, WIDTH: registered result.
- `zero_o`, out, 1: registered flag; high when `result_o == 0`, updated together with `result_o`.
- `valid_o`, out, 1: one-cycle pulse marking `result_o` as new.
- `busy_o`, out, 1: high while in MUL; stall request to the hazard unit.

## Operation
- Two states: IDLE and MUL. `ready_o = (state == IDLE)` and `busy_o = (state == MUL)`.
- Accept in IDLE with op ≠ 5: the result is registered at the accepting edge, `valid_o` = 1 the next cycle, and the state stays IDLE.
- Op results:
  - AND: a&b. XOR: a^b.
  - SLL: a << b[4:0]. SRAI: arithmetic a >>> b[4:0]. Upper bits of b are ignored.
  - ADD/SUB: modulo 2^WIDTH, no overflow flag.
  - Op 7: result 0, `zero_o` = 1, `valid_o` pulses normally.
- Accept in IDLE with op = 5:
  - Latch a into the multiplicand register and b into the multiplier register; clear the accumulator and iteration counter; go to MUL.
- MUL iteration (one per cycle):
  - If multiplier bit 0 = 1, the accumulator gains the multiplicand.
  - Multiplicand shifts left by 1, multiplier shifts right by 1, counter increments.
  - After iteration WIDTH−1, return to IDLE; `result_o` = low WIDTH bits of the accumulator, `valid_o` = 1 for one cycle.
  - The low half is identical for signed and unsigned, so there is no sign handling.
- `valid_i` while in MUL is ignored. It is neither queued nor acknowledged, and the requester must hold it until `ready_o`.
- `valid_o` is never back-pressured; the consumer samples it the cycle it is high.
- While no new result is produced, `result_o` and `zero_o` hold their last values.
- Reset (any time, including mid-MUL):
  - State → IDLE; `result_o` = 0, `zero_o` = 1, `valid_o` = 0, `busy_o` = 0, `ready_o` = 1.
  - Counter and multiplier registers are cleared. An in-flight MUL is dropped with no `valid_o`.

## Timing
- Single-cycle ops: latency 1. Accept at edge N; `valid_o` and the result are visible after edge N+1 is not needed, they are visible in the cycle following edge N. Throughput is one op per cycle with back-to-back accepts allowed.
- MUL: accept at edge N. `busy_o` is high for cycles N+1…N+WIDTH. The result and `valid_o` appear after edge N+WIDTH, giving latency WIDTH+1 = 33 cycles by default.
- `ready_o` is high again in the same cycle that `valid_o` is high for a MUL, so a new request can be accepted on that edge. That request's own `valid_o` follows per the rules above.
- An undefined `aluop3_i` value when `valid_i` = 0 has no effect.

## Structure
- Shared package `alu_pkg`:
  - Op-code constants ALU_AND=0, ALU_XOR=1, ALU_SLL=2, ALU_ADD=3, ALU_SUB=4, ALU_MUL=5, ALU_SRAI=6; these are also used by ALU control.
  - FSM state type {IDLE, MUL}.
- Sub-module `mul_iter`:
  - Contains the multiplicand, multiplier, accumulator and counter registers.
  - Interface: start, a, b → done, product.
- Single-cycle ops are a combinational case in the top level.

## Test plan
- AND/XOR/SLL/ADD/SUB/SRAI back-to-back on consecutive cycles: a=0xF0F0_1234, b=0x0000_0004 → results 0x0000_0004, 0xF0F0_1230, 0x0F01_2340, 0xF0F0_1238, 0xF0F0_1230, 0xFF0F_0123. Each `valid_o` is one cycle after its accept, and `ready_o` stays high throughout.
- SUB with a=5, b=5 → `result_o` = 0 and `zero_o` = 1. ADD with a=0xFFFF_FFFF, b=1 → 0 (wraps) and `zero_o` = 1.
- MUL with a=−3 (0xFFFF_FFFD), b=7 → after exactly 33 cycles `result_o` = 0xFFFF_FFEB. `busy_o` is high for 32 cycles, and `valid_o` pulses exactly once.
- MUL with a=0x0001_0000, b=0x0001_0000 → `result_o` = 0, `zero_o` = 1. `valid_i` with ADD asserted and held during MUL is accepted only on the `valid_o` cycle, and its ADD result follows 1 cycle later.
- Reset asserted (low) at cycle 10 of a MUL → immediately `busy_o` = 0, `ready_o` = 1, `result_o` = 0, `zero_o` = 1. No `valid_o` is produced after release.
- Op 7 with a=b=0xFFFF_FFFF → `result_o` = 0, `zero_o` = 1, `valid_o` pulses after 1 cycle.
